// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional watchdog on a stuck transfer: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  input  logic [15:0]          cfg_divisor,
  output logic                 busy,
  output logic [15:0]          uart_divisor,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_flag,
  output logic                 err
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, idx_q, gnt_idx, cand;
  logic             gnt_vld, tmo;
  logic [7:0]       gnt_data;
  logic [3:0]       gap_q;

  assign busy = (state_q != IDLE);

  // Descending scan so the lowest offset after ptr wins (last write wins).
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    gnt_data = 8'h00;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_idx == IDX_W'(i)) gnt_data = req_data[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (uart_tx_flag || tmo) state_d = GAP;
      GAP:     if (gap_q == 4'(GAP_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      idx_q        <= '0;
      gap_q        <= '0;
      ack          <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      uart_divisor <= 16'd3;
    end else begin
      state_q <= state_d;
      ack     <= '0;
      case (state_q)
        IDLE: begin
          // Divisor only tracks cfg between transfers so a byte never changes baud.
          uart_divisor <= cfg_divisor;
          if (gnt_vld) begin
            idx_q        <= gnt_idx;
            ptr_q        <= gnt_idx;
            uart_tx_data <= gnt_data;
          end
        end
        LOAD: uart_tx_en <= 1'b1;
        SEND: begin
          if (uart_tx_flag) begin
            uart_tx_en <= 1'b0;
            ack        <= NUM_REQ'(1) << idx_q;
            gap_q      <= '0;
          end else if (tmo) begin
            uart_tx_en <= 1'b0;
            gap_q      <= '0;
          end
        end
        GAP:     gap_q <= gap_q + 4'd1;
        default: ;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wdog_q;

  assign tmo = (state_q == SEND) && !uart_tx_flag &&
               (wdog_q == 16'(TIMEOUT_CYCLES - 1));

  // Cleared in LOAD so the count starts at zero on the first SEND cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err    <= 1'b0;
    end else begin
      err <= tmo;
      if (state_q == LOAD)      wdog_q <= '0;
      else if (state_q == SEND) wdog_q <= wdog_q + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter; a grant-order model picks the expected requester.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [15:0] cfg_divisor;
  logic        busy;
  logic [15:0] uart_divisor;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_flag;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int last;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .cfg_divisor(cfg_divisor), .busy(busy), .uart_divisor(uart_divisor),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .uart_tx_flag(uart_tx_flag), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    chk("ack_onehot", 32'($onehot0(ack)), 1);
    chk("ack_vs_en", 32'((|ack) & uart_tx_en), 0);
  endtask

  // Rotating priority: first requester after the last grant, with wrap.
  function automatic int next_grant(input logic [3:0] r, input int l);
    for (int k = 1; k <= N; k++) begin
      int c = (l + k) % N;
      if (r[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic wait_en(output bit ok, output logic [7:0] pd, output logic pe);
    ok = 1'b0;
    pd = uart_tx_data;
    pe = uart_tx_en;
    for (int i = 0; i < 40 && !ok; i++) begin
      pd = uart_tx_data;
      pe = uart_tx_en;
      tick();
      if (uart_tx_en) ok = 1'b1;
    end
  endtask

  // mid: 0 none, 1 change divisor, 2 drop req, 3 change req_data -- applied halfway through SEND
  task automatic xfer(input int exp_i, input int dly, input int mid);
    bit          ok;
    logic [7:0]  pd, exp_d;
    logic        pe;
    logic [15:0] dv;
    exp_d = 8'(req_data >> (8*exp_i));
    dv    = cfg_divisor;
    wait_en(ok, pd, pe);
    chk("en_seen", 32'(ok), 1);
    if (!ok) return;
    chk("data_pre_en", 32'(pd), 32'(exp_d));
    chk("en_pre", 32'(pe), 0);
    chk("div_send", 32'(uart_divisor), 32'(dv));
    for (int i = 0; i < dly; i++) begin
      if (i == dly / 2) begin
        case (mid)
          1: cfg_divisor = 16'd27;
          2: req = req & ~(4'(1) << exp_i);
          3: req_data = (req_data & ~(32'hFF << (8*exp_i))) | (32'(~exp_d) << (8*exp_i));
          default: ;
        endcase
      end
      tick();
      chk("en_hold", 32'(uart_tx_en), 1);
      chk("data_hold", 32'(uart_tx_data), 32'(exp_d));
      chk("div_hold", 32'(uart_divisor), 32'(dv));
      chk("ack_in_send", 32'(ack), 0);
    end
    uart_tx_flag = 1'b1;
    tick();
    uart_tx_flag = 1'b0;
    chk("en_drop", 32'(uart_tx_en), 0);
    chk("ack", 32'(ack), 32'(4'(1) << exp_i));
    chk("busy_gap", 32'(busy), 1);
    for (int i = 0; i < GAP; i++) begin
      tick();
      chk("ack_once", 32'(ack), 0);
    end
    chk("idle_after_gap", 32'(busy), 0);
  endtask

  initial begin
    bit ok;
    logic [7:0] pd;
    logic pe;
    int e, cnt;

    rst = 1'b1; req = '0; req_data = '0; cfg_divisor = 16'd3; uart_tx_flag = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(uart_tx_en), 0);
    chk("rst_data", 32'(uart_tx_data), 0);
    chk("rst_div", 32'(uart_divisor), 3);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    last = N - 1;

    // single requester
    req = 4'b0100; req_data[23:16] = 8'h8E;
    xfer(2, 20, 0); last = 2; req = '0;

    // flag while idle is ignored
    uart_tx_flag = 1'b1; tick(); uart_tx_flag = 1'b0;
    chk("spur_busy", 32'(busy), 0);
    chk("spur_ack", 32'(ack), 0);
    tick();
    chk("spur_busy2", 32'(busy), 0);
    chk("spur_en", 32'(uart_tx_en), 0);

    // divisor change during SEND
    req = 4'b0001; req_data[7:0] = 8'h5A;
    e = next_grant(req, last);
    xfer(e, 6, 1); last = e; req = '0;
    tick();
    chk("div_new", 32'(uart_divisor), 27);

    // req drop mid-send, then data change after grant
    req = 4'b0110; req_data[15:8] = 8'hC3;
    e = next_grant(req, last);
    xfer(e, 6, 2); last = e; req = '0;
    req = 4'b1000; req_data[31:24] = 8'h3C;
    e = next_grant(req, last);
    xfer(e, 6, 3); last = e; req = '0;

    // reset in SEND
    req = 4'b0100;
    wait_en(ok, pd, pe);
    chk("mr_en_seen", 32'(ok), 1);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_en", 32'(uart_tx_en), 0);
    chk("mr_ack", 32'(ack), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_div", 32'(uart_divisor), 3);
    req = 4'b1001; req_data[7:0] = 8'h11; req_data[31:24] = 8'h99;
    xfer(0, 4, 0); last = 0; req = '0;

    // round-robin from reset
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; req_data = 32'hA3A2A1A0;
    for (int n = 0; n < 5; n++) xfer(n % 4, 3, 0);
    last = 0; req = '0;

`ifdef UART_ARB_TIMEOUT_EN
    req = 4'b0011;
    wait_en(ok, pd, pe);
    chk("tmo_en_seen", 32'(ok), 1);
    cnt = 0;
    for (int i = 0; i < 100 && !err; i++) begin
      tick(); cnt++;
      if (!err) chk("tmo_no_ack", 32'(ack), 0);
    end
    chk("tmo_cycles", 32'(cnt), TMO);
    chk("tmo_ack", 32'(ack), 0);
    chk("tmo_en", 32'(uart_tx_en), 0);
    last = next_grant(req, last);
    e = next_grant(req, last);
    xfer(e, 3, 0); last = e; req = '0;
`endif

    // randomized masks, data and flag delay
    for (int n = 0; n < 12; n++) begin
      req      = 4'($urandom_range(1, 15));
      req_data = $urandom;
      e = next_grant(req, last);
      xfer(e, int'($urandom_range(1, 8)), 0);
      last = e;
    end
    req = '0;
    tick();
    chk("end_idle", 32'(busy), 0);
`ifndef UART_ARB_TIMEOUT_EN
    chk("err_tied", 32'(err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8-bit parallel in, enable, done flag, 16-bit baud divisor) among NUM_REQ requesters.
- Uses round-robin arbitration and sequences each byte transfer with the tx_en/tx_flag handshake.
- Latches the baud divisor into the UART only between transfers.
- Sits between requesting client logic and the uart block, driving its divisor, tx_en and para_data_in.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles forced on uart_tx_en between consecutive bytes (1..15).
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles for one byte (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req  in  NUM_REQ  per-requester byte request; level, held until ack.
- req_data  in  NUM_REQ*8  packed bytes; requester i at bits [8i+7:8i].
- ack  out  NUM_REQ  one-hot, one-cycle pulse when requester's byte has finished on the line.
- cfg_divisor  in  16  desired baud divisor.
- busy  out  1  high in any state other than IDLE.
- uart_divisor  out  16  to uart divisor.
- uart_tx_en  out  1  to uart tx_en.
- uart_tx_data  out  8  to uart para_data_in.
- uart_tx_flag  in  1  from uart tx_flag; one-cycle pulse at end of stop bit.
- err  out  1  timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: ack=0, busy=0, uart_tx_en=0, uart_tx_data=8'h00, uart_divisor=16'd3, err=0, state=IDLE, rr pointer=NUM_REQ-1 (so requester 0 wins first), gap counter=0.

States and transitions:
- IDLE
  - Every cycle: uart_divisor <= cfg_divisor.
  - If any req is high: grant the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap.
  - On grant: latch idx, latch uart_tx_data <= req_data[idx], ptr <= idx, go to LOAD.
- LOAD (1 cycle)
  - uart_tx_en stays 0, so data is stable one cycle before enable.
  - Go to SEND.
- SEND
  - uart_tx_en=1.
  - On uart_tx_flag=1: uart_tx_en<=0, ack[idx] pulses on the next cycle, go to GAP.
- GAP
  - uart_tx_en=0 for GAP_CYCLES cycles, then go to IDLE.
  - An ack-to-next-grant turnaround of at least GAP_CYCLES+1 cycles is guaranteed.

Latency and ordering:
- Minimum req-to-uart_tx_en latency is 2 cycles (IDLE sample, LOAD).

Rules and boundary conditions:
- uart_divisor never changes outside IDLE; a cfg_divisor change during a transfer takes effect in the first IDLE cycle after the transfer.
- uart_tx_flag outside SEND is ignored.
- A req drop during LOAD/SEND does not abort: the byte completes and ack still pulses; the requester must tolerate this.
- req_data changes after grant have no effect; data is latched in IDLE.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,3,0,…; no requester waits more than NUM_REQ-1 transfers.
- Single requester: consecutive grants to the same index are allowed after GAP.
- rst mid-operation: return to reset values on the next edge, uart_tx_en drops the same edge, no ack issued, ptr resets.
- Exactly one ack bit ever high; ack never coincides with uart_tx_en=1.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined, a 16-bit watchdog counts cycles in SEND.
  - Reaching TIMEOUT_CYCLES without uart_tx_flag causes: uart_tx_en<=0, err pulses 1 cycle, no ack, go to GAP, ptr still advances.
  - The watchdog clears on entering SEND.
- When undefined: no counter, err tied 0, SEND waits indefinitely.

Test Plan:
- Reset then single request
  - Stimulus: rst 1 for 3 cycles; req=4'b0100, req_data[23:16]=8'h8E; model uart_tx_flag 20 cycles after tx_en rises.
  - Required: uart_tx_data=8'h8E exactly 1 cycle before uart_tx_en=1; ack=4'b0100 one cycle after flag; busy low after GAP.
- Round-robin
  - Stimulus: req=4'b1111 held, data 8'hA0..8'hA3.
  - Required: UART bytes A0,A1,A2,A3,A0; acks rotate one-hot in the same order.
- Divisor latch
  - Stimulus: cfg_divisor changes 3→27 while in SEND.
  - Required: uart_divisor stays 3 until the first IDLE cycle after the transfer, then 27.
- Spurious flag and req drop
  - Stimulus: uart_tx_flag pulse in IDLE; separately, req dropped mid-SEND.
  - Required: the IDLE flag has no state change and no ack; the dropped transfer still completes with ack.
- Mid-transfer reset
  - Stimulus: rst=1 during SEND.
  - Required: uart_tx_en=0 next edge, ack=0, ptr reset (requester 0 wins next).
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50)
  - Stimulus: never pulse uart_tx_flag.
  - Required: err pulse 50 cycles into SEND, no ack, next requester granted.
